// File: rtl/mux_pkg.sv
// Shared constants and helpers for the select-mux / demux-dispatch stream blocks.
package mux_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned NPORT = 5;
  localparam int unsigned DST_W = 3;

  // All-ones destination code means "deliver to every port".
  localparam logic [DST_W-1:0] BCAST_DST = {DST_W{1'b1}};

  function automatic logic is_valid_dst(input logic [DST_W-1:0] dst);
    return 32'(dst) < NPORT;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: data register plus valid flag, drained by its own ready.
module demux_slot #(
  parameter int unsigned DW = 16
) (
  input  logic          mclk,
  input  logic          mreset,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          free
);

  logic          valid_d, valid_q;
  logic [DW-1:0] data_d, data_q;

  // A load wins over a drain in the same cycle, so the flag stays set.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge mreset) begin
    if (mreset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign free      = !valid_q || out_ready;

endmodule

// File: rtl/demux_dispatch.sv
// One-to-NPORT stream demultiplexer with unicast, all-or-nothing broadcast and
// counted drop of invalid destinations.
module demux_dispatch #(
  parameter int unsigned DW    = mux_pkg::DW,
  parameter int unsigned NPORT = mux_pkg::NPORT,
  parameter int unsigned DST_W = mux_pkg::DST_W
) (
  input  logic                mclk,
  input  logic                mreset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DST_W-1:0]    in_dst,
  input  logic [DW-1:0]       in_data,
  output logic [NPORT-1:0]    out_valid,
  input  logic [NPORT-1:0]    out_ready,
  output logic [NPORT*DW-1:0] out_data,
  output logic                err_drop,
  output logic [7:0]          drop_cnt
);

  import mux_pkg::BCAST_DST;
  import mux_pkg::is_valid_dst;

  logic [NPORT-1:0] uni_sel;
  logic [NPORT-1:0] free;
  logic [NPORT-1:0] load;
  logic             is_bcast;
  logic             is_uni;
  logic             accept;
  logic             drop;
  logic             err_drop_d, err_drop_q;
  logic [7:0]       drop_cnt_d, drop_cnt_q;

  always_comb begin
    uni_sel = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      uni_sel[p] = (in_dst == DST_W'(p));
    end
  end

  assign is_bcast = (in_dst == BCAST_DST);
  assign is_uni   = is_valid_dst(in_dst);

  // Depends only on in_dst and slot state, never on in_valid.
  always_comb begin
    in_ready = 1'b1;
    if (is_bcast) begin
      in_ready = &free;
    end else if (is_uni) begin
      in_ready = |(uni_sel & free);
    end
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && !is_bcast && !is_uni;

  always_comb begin
    load = '0;
    if (accept) begin
      if (is_bcast) begin
        load = '1;
      end else if (is_uni) begin
        load = uni_sel;
      end
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_slot
    demux_slot #(
      .DW(DW)
    ) u_slot (
      .mclk     (mclk),
      .mreset   (mreset),
      .load     (load[p]),
      .load_data(in_data),
      .out_ready(out_ready[p]),
      .out_valid(out_valid[p]),
      .out_data (out_data[p*DW +: DW]),
      .free     (free[p])
    );
  end

  always_comb begin
    err_drop_d = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge mclk or posedge mreset) begin
    if (mreset) begin
      err_drop_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_drop_q <= err_drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign err_drop = err_drop_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_dispatch.sv
// Directed-vector bench for demux_dispatch with hand-computed expectations.
module tb_demux_dispatch;

  localparam int DW = 16;
  localparam int NP = 5;

  logic          mclk = 1'b0;
  logic          mreset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_dst;
  logic [DW-1:0] in_data;
  logic [NP-1:0] out_valid;
  logic [NP-1:0] out_ready;
  logic [NP*DW-1:0] out_data;
  logic          err_drop;
  logic [7:0]    drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  demux_dispatch dut (
    .mclk     (mclk),
    .mreset   (mreset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dst   (in_dst),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err_drop (err_drop),
    .drop_cnt (drop_cnt)
  );

  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic test_reset();
    mreset = 1'b1; in_valid = 1'b0; in_dst = 3'd0; in_data = '0; out_ready = '1;
    step(); step();
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++;
      $display("FAIL reset_valid got=%b want=00000", out_valid); end
    n_cmp++; if (out_data !== 80'h0) begin n_err++;
      $display("FAIL reset_data got=%h want=0", out_data); end
    n_cmp++; if (err_drop !== 1'b0) begin n_err++;
      $display("FAIL reset_err got=%b want=0", err_drop); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++;
      $display("FAIL reset_cnt got=%0d want=0", drop_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_ready got=%b want=1", in_ready); end
    mreset = 1'b0;
    step();
  endtask

  task automatic test_unicast();
    out_ready = '1; in_valid = 1'b1; in_dst = 3'd2; in_data = 16'hA5A5;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL uni_ready got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 5'b00100) begin n_err++;
      $display("FAIL uni_valid got=%b want=00100", out_valid); end
    n_cmp++; if (out_data[2*DW +: DW] !== 16'hA5A5) begin n_err++;
      $display("FAIL uni_data got=%h want=a5a5", out_data[2*DW +: DW]); end
    step();
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++;
      $display("FAIL uni_drain got=%b want=00000", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 5'b11110; in_valid = 1'b1; in_dst = 3'd0; in_data = 16'h0001;
    step();
    in_data = 16'h0002;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++;
      $display("FAIL bp_ready got=%b want=0", in_ready); end
    n_cmp++; if (out_data[DW-1:0] !== 16'h0001 || out_valid[0] !== 1'b1) begin n_err++;
      $display("FAIL bp_hold got=%h/%b want=0001/1", out_data[DW-1:0], out_valid[0]); end
    step();
    n_cmp++; if (out_data[DW-1:0] !== 16'h0001 || in_ready !== 1'b0) begin n_err++;
      $display("FAIL bp_stable got=%h rdy=%b want=0001 rdy=0", out_data[DW-1:0], in_ready); end
    out_ready = 5'b11111;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_data[DW-1:0] !== 16'h0001) begin n_err++;
      $display("FAIL bp_release got=rdy%b %h want=rdy1 0001", in_ready, out_data[DW-1:0]); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid[0] !== 1'b1 || out_data[DW-1:0] !== 16'h0002) begin n_err++;
      $display("FAIL bp_second got=%b/%h want=1/0002", out_valid[0], out_data[DW-1:0]); end
    step();
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++;
      $display("FAIL bp_empty got=%b want=00000", out_valid); end
  endtask

  task automatic test_broadcast();
    out_ready = 5'b01111; in_valid = 1'b1; in_dst = 3'd4; in_data = 16'h4444;
    step();
    in_dst = 3'd7; in_data = 16'h1234;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++;
      $display("FAIL bc_gate got=%b want=0", in_ready); end
    step();
    n_cmp++; if (out_valid !== 5'b10000 || out_data[4*DW +: DW] !== 16'h4444) begin n_err++;
      $display("FAIL bc_noload got=%b/%h want=10000/4444", out_valid, out_data[4*DW +: DW]); end
    out_ready = 5'b11111;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL bc_open got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 5'b11111) begin n_err++;
      $display("FAIL bc_valid got=%b want=11111", out_valid); end
    for (int p = 0; p < NP; p++) begin
      n_cmp++; if (out_data[p*DW +: DW] !== 16'h1234) begin n_err++;
        $display("FAIL bc_data%0d got=%h want=1234", p, out_data[p*DW +: DW]); end
    end
    step();
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++;
      $display("FAIL bc_drain got=%b want=00000", out_valid); end
  endtask

  task automatic test_invalid();
    out_ready = '1; in_valid = 1'b1; in_dst = 3'd5; in_data = 16'hDEAD;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL inv_ready got=%b want=1", in_ready); end
    step();
    in_dst = 3'd6;
    n_cmp++; if (err_drop !== 1'b1 || out_valid !== 5'b00000 || drop_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL inv_first got=err%b v%b c%0d want=err1 v00000 c1",
               err_drop, out_valid, drop_cnt); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (err_drop !== 1'b1 || drop_cnt !== 8'd2 || out_valid !== 5'b00000) begin
      n_err++;
      $display("FAIL inv_second got=err%b c%0d v%b want=err1 c2 v00000",
               err_drop, drop_cnt, out_valid); end
    step();
    n_cmp++; if (err_drop !== 1'b0) begin n_err++;
      $display("FAIL inv_pulse got=%b want=0", err_drop); end
    in_valid = 1'b1; in_dst = 3'd5;
    repeat (300) step();
    in_valid = 1'b0;
    n_cmp++; if (drop_cnt !== 8'd255) begin n_err++;
      $display("FAIL inv_sat got=%0d want=255", drop_cnt); end
    n_cmp++; if (err_drop !== 1'b1) begin n_err++;
      $display("FAIL inv_sat_pulse got=%b want=1", err_drop); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = '1; in_valid = 1'b1; in_dst = 3'd1; in_data = 16'h1111;
    step();
    in_data = 16'hBEEF;
    n_cmp++; if (in_ready !== 1'b1 || out_valid[1] !== 1'b1) begin n_err++;
      $display("FAIL b2b_ready got=rdy%b v%b want=rdy1 v1", in_ready, out_valid[1]); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid[1] !== 1'b1 || out_data[DW +: DW] !== 16'hBEEF) begin n_err++;
      $display("FAIL b2b_replace got=%b/%h want=1/beef", out_valid[1], out_data[DW +: DW]); end
    step();
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++;
      $display("FAIL b2b_drain got=%b want=00000", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = '0; in_valid = 1'b1;
    in_dst = 3'd0; in_data = 16'h0A0A; step();
    in_dst = 3'd2; in_data = 16'h0B0B; step();
    in_dst = 3'd3; in_data = 16'h0C0C; step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 5'b01101) begin n_err++;
      $display("FAIL rst_pre got=%b want=01101", out_valid); end
    #2 mreset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 5'b00000 || drop_cnt !== 8'd0) begin n_err++;
      $display("FAIL rst_async got=v%b c%0d want=v00000 c0", out_valid, drop_cnt); end
    out_ready = '1; in_valid = 1'b1; in_dst = 3'd0; in_data = 16'h5555;
    step();
    n_cmp++; if (out_valid !== 5'b00000) begin n_err++;
      $display("FAIL rst_noaccept got=%b want=00000", out_valid); end
    mreset = 1'b0;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 5'b00001 || out_data[DW-1:0] !== 16'h5555) begin n_err++;
      $display("FAIL rst_resume got=%b/%h want=00001/5555", out_valid, out_data[DW-1:0]); end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
